// File: rtl/clint_timer_pkg.sv
// clint_timer_pkg: CLINT register offsets, mip bit positions, bus FSM encoding and decode helpers
package clint_timer_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI_OFF = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO_OFF    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI_OFF    = 16'hBFFC;

    localparam int MIP_MTIP_BIT = 7;
    localparam int MIP_MSIP_BIT = 3;

    typedef enum logic {IDLE, RESP} bus_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] off);
        return addr[15:2] == off[15:2];
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// clint_timer_if: request/ack data-memory bus into the CLINT window
interface clint_timer_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master(output req, we, addr, wdata, wstrb, input ready, rvalid, rdata);
    modport slave(input req, we, addr, wdata, wstrb, output ready, rvalid, rdata);
endinterface

// File: rtl/clint_timer_prescaler.sv
// clint_timer_prescaler: divides clk by PRESCALE into mtime ticks; hold masks a tick without disturbing the count
module clint_timer_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold_i,
    output logic tick_o
);

    logic [15:0] cnt_q, cnt_d;
    logic        wrap;

    assign wrap   = cnt_q == 16'(PRESCALE - 1);
    assign tick_o = wrap & ~hold_i;

    // free-running 0..PRESCALE-1 counter, never stalled by hold
    always_comb cnt_d = wrap ? '0 : cnt_q + 16'd1;

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_timer.sv
// clint_timer: CLINT mtime/mtimecmp/msip unit with registered mtip; optional msip register under CLINT_MSIP_EN
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter int unsigned PRESCALE   = 1,
    parameter logic [15:0] BASE_MATCH = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    clint_timer_if.slave  bus,
    output logic          mtip,
    output logic          msip
);

    bus_state_e  state_q, state_d;
    logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
    logic [31:0] rdata_q, rdata_d, rd_val, wr_lo, wr_hi, cmp_lo, cmp_hi;
    logic        mtip_q, accept, wr, tick, hold;
    logic        hit_msip, hit_clo, hit_chi, hit_tlo, hit_thi;
    logic        unused_bits;

    assign unused_bits = ^{BASE_MATCH, bus.addr[1:0]};

    assign accept   = bus.req & bus.ready;
    assign wr       = accept & bus.we;
    assign hit_msip = addr_hit(bus.addr, CLINT_MSIP_OFF);
    assign hit_clo  = addr_hit(bus.addr, CLINT_MTIMECMP_LO_OFF);
    assign hit_chi  = addr_hit(bus.addr, CLINT_MTIMECMP_HI_OFF);
    assign hit_tlo  = addr_hit(bus.addr, CLINT_MTIME_LO_OFF);
    assign hit_thi  = addr_hit(bus.addr, CLINT_MTIME_HI_OFF);
    assign hold     = wr & (hit_tlo | hit_thi);

    clint_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .hold_i(hold),
        .tick_o(tick)
    );

    // bus FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // every accepted request is acked exactly one cycle later
    always_comb state_d = (state_q == IDLE && bus.req) ? RESP : IDLE;

    // handshake outputs; rvalid is cut by reset in the same cycle
    always_comb begin
        bus.ready  = state_q == IDLE;
        bus.rvalid = (state_q == RESP) & rst_n;
        bus.rdata  = rdata_q;
    end

    // mtime half writes replace one half and drop that cycle's increment, so no carry crosses halves
    always_comb begin
        wr_lo      = byte_merge(mtime_q[31:0], bus.wdata, bus.wstrb);
        wr_hi      = byte_merge(mtime_q[63:32], bus.wdata, bus.wstrb);
        cmp_lo     = byte_merge(mtimecmp_q[31:0], bus.wdata, bus.wstrb);
        cmp_hi     = byte_merge(mtimecmp_q[63:32], bus.wdata, bus.wstrb);
        mtime_d    = (wr & hit_tlo) ? {mtime_q[63:32], wr_lo} :
                     (wr & hit_thi) ? {wr_hi, mtime_q[31:0]} :
                     tick           ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = (wr & hit_clo) ? {mtimecmp_q[63:32], cmp_lo} :
                     (wr & hit_chi) ? {cmp_hi, mtimecmp_q[31:0]} : mtimecmp_q;
        rd_val     = hit_tlo  ? mtime_q[31:0] :
                     hit_thi  ? mtime_q[63:32] :
                     hit_clo  ? mtimecmp_q[31:0] :
                     hit_chi  ? mtimecmp_q[63:32] :
                     hit_msip ? {31'd0, msip} : 32'd0;
        rdata_d    = (accept & ~bus.we) ? rd_val : 32'd0;
    end

    // timer registers, read-data capture and registered compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            rdata_q    <= '0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            mtip_q     <= mtime_q >= mtimecmp_q;
        end
    end

    assign mtip = mtip_q;

`ifdef CLINT_MSIP_EN
    logic msip_q;

    // software interrupt bit, written through byte lane 0
    always_ff @(posedge clk) begin
        if (!rst_n)                                msip_q <= 1'b0;
        else if (wr & hit_msip & bus.wstrb[0])     msip_q <= bus.wdata[0];
    end

    assign msip = msip_q;
`else
    assign msip = 1'b0;
`endif

endmodule

// File: doc/clint_timer.md
Name: clint_timer

Overview:
- Machine-level timer and software-interrupt unit (CLINT subset). It sits upstream of the CSR block and drives that block's mtip input.
- It holds a free-running 64-bit mtime counter and a 64-bit mtimecmp compare register, both memory-mapped on the data-memory bus through a simple request/ack handshake.
- It raises mtip while mtime >= mtimecmp.

Parameters:
- PRESCALE, 1, number of clk cycles per mtime increment (legal range 1..65535).
- BASE_MATCH, 16'h0000, reserved; address decode uses addr[15:0] only.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- req  in  1  bus request, qualified by ready
- we  in  1  1 = write, 0 = read
- addr  in  16  byte offset within the CLINT window; word aligned, addr[1:0] ignored
- wdata  in  32  write data
- wstrb  in  4  byte enables for writes
- ready  out  1  unit can accept a request this cycle
- rvalid  out  1  one-cycle ack for every accepted request (read or write)
- rdata  out  32  read data, valid while rvalid = 1
- mtip  out  1  machine timer interrupt pending (to csr.mtip)
- msip  out  1  machine software interrupt pending

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, prescaler = 0, msip register = 0.
  - State = IDLE, ready = 1, rvalid = 0, rdata = 0, mtip = 0.
- Register map:
  - 0x0000 msip (bit 0 only; other bits read 0)
  - 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32]
  - 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32]
  - Any other offset: read returns 0, write is ignored, and rvalid is still returned.
- Handshake FSM:
  - IDLE: ready = 1. On req & ready, the request is accepted: a write updates its register on this same edge; a read samples its register on this same edge. Next state = RESP.
  - RESP: ready = 0, rvalid = 1, rdata = the sampled value (0 for writes). Next state = IDLE unconditionally.
  - Maximum throughput is one request every 2 cycles. A req asserted while in RESP is not accepted; the master holds it until ready = 1.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - On reaching PRESCALE-1 it wraps to 0 and mtime increments by 1 (full 64-bit carry).
  - With PRESCALE = 1, mtime increments every cycle.
  - mtime 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Write to an mtime half:
  - Byte-masked replace of that half only.
  - The other half holds its pre-write value.
  - The increment scheduled for that cycle is dropped; no carry is applied between halves.
  - The prescaler is not disturbed.
- Write to an mtimecmp half: byte-masked replace; the other half is unchanged.
- Read of an mtime half returns the pre-increment value at the accept edge. Software reads hi/lo/hi for coherence; the block provides no latching.
- mtip is registered: on each edge, mtip <= (mtime >= mtimecmp) using the current register values, unsigned 64-bit compare. mtip therefore lags a counter or compare change by one cycle.
- mtip is level, not sticky; it deasserts one cycle after a write makes mtimecmp > mtime.
- A write with wstrb = 0 has no register effect but is still acked.
- Reset during RESP: the FSM returns to IDLE and rvalid drops in the reset cycle.

Optional Feature:
- Macro CLINT_MSIP_EN.
- Defined: offset 0x0000 is a read/write register; bit 0 is written when wstrb[0] = 1, and msip = that bit.
- Undefined: msip is tied 0, offset 0x0000 reads 0, and writes to it are ignored but acked.

Decomposition:
- Shared package (riscv_pkg):
  - CLINT_MSIP_OFF = 16'h0000, CLINT_MTIMECMP_LO_OFF = 16'h4000, CLINT_MTIMECMP_HI_OFF = 16'h4004, CLINT_MTIME_LO_OFF = 16'hBFF8, CLINT_MTIME_HI_OFF = 16'hBFFC
  - MIP_MTIP_BIT = 7, MIP_MSIP_BIT = 3
  - 2-state bus FSM encoding (IDLE, RESP)
- One natural sub-module: clint_prescaler, the tick generator. Its outputs are `tick` plus a `hold` input that suppresses the increment on mtime-write cycles.

Test Plan:
- Reset then 10 idle cycles, PRESCALE = 1 -> read 0xBFF8 returns 10 + read-issue offset (exact: accept-cycle count); mtip = 0 throughout.
- Write mtimecmp lo = 20, hi = 0; let time run -> mtip rises exactly 1 cycle after mtime reaches 20 and stays high.
- With mtip = 1, write mtimecmp hi = 1 -> mtip = 0 one cycle after the accept edge.
- Write mtime lo = 32'hFFFF_FFFF, hi = 0; wait 2 increments -> read hi = 1, lo = 1 (carry across halves).
- PRESCALE = 4: sample mtime 100 cycles apart -> delta = 25; write 0x1234_0000 with wstrb = 4'b1100 to 0x4000 -> lo = 0x1234_FFFF.
- Back-to-back req held high -> accepts only on alternate cycles; rvalid pulses 1 cycle each; unmapped 0x8000 read -> rdata = 0 with rvalid. CLINT_MSIP_EN defined: write 1 to 0x0000 -> msip = 1; undefined -> msip stays 0.
